// File: rtl/store_encoder_axi_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : store_encoder_axi_if
// Description : Store request/response handshake plus AXI4-Lite write channels
//               (AW, W, B) seen by the store encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_encoder_axi_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [2:0]        req_funct3;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_err;
    logic              resp_misalign;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    // Encoder side: consumes requests, masters the AXI write channels.
    modport master (
        input  req_valid, req_addr, req_data, req_funct3, resp_ready,
               awready, wready, bvalid, bresp,
        output req_ready, resp_valid, resp_err, resp_misalign,
               awvalid, awaddr, wvalid, wdata, wstrb, bready
    );

    // Environment side: pipeline plus AXI slave.
    modport slave (
        output req_valid, req_addr, req_data, req_funct3, resp_ready,
               awready, wready, bvalid, bresp,
        input  req_ready, resp_valid, resp_err, resp_misalign,
               awvalid, awaddr, wvalid, wdata, wstrb, bready
    );
endinterface
`default_nettype wire

// File: rtl/store_encoder_axi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : store_encoder_axi
// Description : Encodes SB/SH/SW stores into byte-lane data/strobes and issues
//               one AXI4-Lite write. Macro STORE_MISALIGN_TRAP_EN rejects
//               misaligned SH/SW instead of issuing them shifted.
// Revision    : 1.0 - initial release
// ============================================================================
module store_encoder_axi #(
    parameter int ADDR_W       = 32,
    parameter bit ALIGN_AWADDR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    store_encoder_axi_if.master  bus
);
    localparam logic [2:0] c_F3_SB = 3'b000;
    localparam logic [2:0] c_F3_SH = 3'b001;
    localparam logic [2:0] c_F3_SW = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_B = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            r_state_q,  w_state_d;
    logic [ADDR_W-1:0] r_awaddr_q, w_awaddr_d;
    logic [31:0]       r_wdata_q,  w_wdata_d;
    logic [3:0]        r_wstrb_q,  w_wstrb_d;
    logic              r_aw_pend_q, w_aw_pend_d;
    logic              r_w_pend_q,  w_w_pend_d;
    logic              r_err_q,     w_err_d;
    logic              r_mis_q,     w_mis_d;

    logic [1:0]        w_off;
    logic              w_illegal;
    logic              w_misaligned;
    logic              w_trap_mis;
    logic [3:0]        w_enc_strb;
    logic [31:0]       w_enc_data;
    logic [ADDR_W-1:0] w_enc_addr;
    logic              w_unused_bresp;

    assign w_unused_bresp = bus.bresp[0];

    always_comb begin
        w_off        = bus.req_addr[1:0];
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_enc_strb   = 4'b0000;
        w_enc_data   = bus.req_data;
        case (bus.req_funct3)
            c_F3_SB: begin
                w_enc_strb = 4'b0001 << w_off;
                w_enc_data = {4{bus.req_data[7:0]}};
            end
            c_F3_SH: begin
                w_misaligned = w_off[0];
                w_enc_strb   = 4'b0011 << w_off;
                w_enc_data   = {2{bus.req_data[15:0]}};
            end
            c_F3_SW: begin
                w_misaligned = (w_off != 2'b00);
                w_enc_strb   = 4'b1111 << w_off;
                w_enc_data   = bus.req_data;
            end
            default: w_illegal = 1'b1;
        endcase
`ifndef STORE_MISALIGN_TRAP_EN
        // Unchecked misaligned access: lanes above the word boundary are dropped.
        if (w_misaligned) begin
            w_enc_data = bus.req_data << {w_off, 3'b000};
        end
`endif
    end

`ifdef STORE_MISALIGN_TRAP_EN
    assign w_trap_mis = w_misaligned;
`else
    assign w_trap_mis = 1'b0;
`endif

    generate
        if (ALIGN_AWADDR) begin : g_align_awaddr
            assign w_enc_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
        end else begin : g_pass_awaddr
            assign w_enc_addr = bus.req_addr;
        end
    endgenerate

    always_comb begin
        w_state_d   = r_state_q;
        w_awaddr_d  = r_awaddr_q;
        w_wdata_d   = r_wdata_q;
        w_wstrb_d   = r_wstrb_q;
        w_aw_pend_d = r_aw_pend_q;
        w_w_pend_d  = r_w_pend_q;
        w_err_d     = r_err_q;
        w_mis_d     = r_mis_q;
        case (r_state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_awaddr_d = w_enc_addr;
                    w_wdata_d  = w_enc_data;
                    w_wstrb_d  = w_enc_strb;
                    if (w_illegal || w_trap_mis) begin
                        w_state_d = ST_RESP;
                        w_err_d   = 1'b1;
                        w_mis_d   = w_trap_mis;
                    end else begin
                        w_state_d   = ST_ISSUE;
                        w_aw_pend_d = 1'b1;
                        w_w_pend_d  = 1'b1;
                        w_err_d     = 1'b0;
                        w_mis_d     = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                // AW and W retire independently; B is only accepted after both.
                if (r_aw_pend_q && bus.awready) w_aw_pend_d = 1'b0;
                if (r_w_pend_q && bus.wready)   w_w_pend_d  = 1'b0;
                if (!w_aw_pend_d && !w_w_pend_d) w_state_d = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (bus.bvalid) begin
                    w_err_d   = bus.bresp[1];
                    w_mis_d   = 1'b0;
                    w_state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_awaddr_q  <= '0;
            r_wdata_q   <= '0;
            r_wstrb_q   <= '0;
            r_aw_pend_q <= 1'b0;
            r_w_pend_q  <= 1'b0;
            r_err_q     <= 1'b0;
            r_mis_q     <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_awaddr_q  <= w_awaddr_d;
            r_wdata_q   <= w_wdata_d;
            r_wstrb_q   <= w_wstrb_d;
            r_aw_pend_q <= w_aw_pend_d;
            r_w_pend_q  <= w_w_pend_d;
            r_err_q     <= w_err_d;
            r_mis_q     <= w_mis_d;
        end
    end

    assign bus.req_ready     = (r_state_q == ST_IDLE);
    assign bus.awvalid       = (r_state_q == ST_ISSUE) && r_aw_pend_q;
    assign bus.wvalid        = (r_state_q == ST_ISSUE) && r_w_pend_q;
    assign bus.bready        = (r_state_q == ST_WAIT_B);
    assign bus.resp_valid    = (r_state_q == ST_RESP);
    assign bus.resp_err      = r_err_q;
    assign bus.resp_misalign = r_mis_q;
    assign bus.awaddr        = r_awaddr_q;
    assign bus.wdata         = r_wdata_q;
    assign bus.wstrb         = r_wstrb_q;
endmodule
`default_nettype wire

// File: doc/store_encoder_axi.md
Name: store_encoder_axi

Overview:
- Write-side counterpart of the load-data decoder.
- Accepts a store request from the execute stage: address, rs2 data and funct3 (SB/SH/SW).
- Builds the byte-lane write data and strobes, checks alignment, and drives one AXI4-Lite write transaction (AW, W, B).
- Returns a completion/error response to the pipeline. Sits between EXU and the data-memory AXI4-Lite master port.

Parameters:
- ADDR_W, 32, address width of req_addr and awaddr.
- ALIGN_AWADDR, 1, 1 = awaddr[1:0] forced to 0 (word-aligned bus address); 0 = awaddr passes the full request address.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  store request valid
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  byte address
- req_data  in  32  rs2 value, unshifted
- req_funct3  in  3  000 = SB, 001 = SH, 010 = SW
- resp_valid  out  1  completion valid
- resp_ready  in  1  pipeline accepts completion
- resp_err  out  1  bus error, illegal funct3 or misaligned access
- resp_misalign  out  1  error cause was misalignment
- awvalid  out  1  AXI write address valid
- awready  in  1
- awaddr  out  ADDR_W
- wvalid  out  1  AXI write data valid
- wready  in  1
- wdata  out  32
- wstrb  out  4
- bvalid  in  1
- bready  out  1
- bresp  in  2

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State becomes IDLE.
  - req_ready=1.
  - resp_valid, resp_err, resp_misalign, awvalid, wvalid, bready all 0.
  - awaddr, wdata, wstrb = 0.
- Reset mid-transaction abandons it at once: all valids and bready are 0 the next cycle.
- States: IDLE, ISSUE, WAIT_B, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request and compute the encoding below in the same edge.
  - Illegal funct3 or a misalignment error goes to RESP with resp_err=1. No bus activity.
  - Otherwise go to ISSUE.
- Encoding, with off = req_addr[1:0]:
  - SB: wdata = {4{data[7:0]}}; wstrb = 0001 << off.
  - SH: wdata = {2{data[15:0]}}; wstrb = 0011 << off.
  - SW: wdata = data; wstrb = 1111.
  - Misaligned: SH with off[0]=1, or SW with off≠0.
- ISSUE:
  - awvalid and wvalid are both asserted on entry.
  - Each is dropped independently in the cycle after its own handshake (valid&ready).
  - awaddr, wdata and wstrb are stable while the matching valid is high.
  - Go to WAIT_B once both handshakes are done. The two may complete in the same cycle or in any order.
- WAIT_B:
  - bready=1.
  - On bvalid: resp_err = bresp[1]; resp_misalign = 0; go to RESP.
  - bvalid arriving while still in ISSUE is not accepted (bready=0).
- RESP:
  - resp_valid=1; resp fields are held stable.
  - On resp_ready go to IDLE. req_ready rises the cycle after.
- Latency with all ready/valid inputs tied 1: request accepted at cycle 0, AW and W handshakes at cycle 1, B at cycle 2, resp_valid at cycle 3. 4-cycle throughput.
- One transaction in flight at most. No buffering.
- req_ready=0 in every state other than IDLE.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned SH/SW is rejected: RESP with resp_err=1, resp_misalign=1, no AW/W issued.
  - Response appears 1 cycle after acceptance.
- Undefined:
  - Misalignment is not checked; resp_misalign is tied 0.
  - Strobe is (base mask << off) truncated to 4 bits. wdata is data << (8*off).
  - Example: SW at off=1 writes bytes 1–3 with data[23:0]. Normal bus transaction.

Test Plan:
- SB addr 0x80000003, data 0x12345678, all readies 1 → awaddr 0x80000000, wdata 0x78787878, wstrb 1000, resp_valid at cycle 3, resp_err=0.
- SH addr 0x80000002, data 0xCAFEBEEF; awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 4 cycles, wstrb 1100, wdata 0xBEEFBEEF, bready only after both handshakes.
- SW addr 0x80000100, bresp=2'b10 → resp_err=1, resp_misalign=0; resp held 5 cycles with resp_ready=0; req_ready=0 throughout.
- SW addr 0x80000002:
  - With STORE_MISALIGN_TRAP_EN: resp_err=1, resp_misalign=1, awvalid never asserted.
  - Without it: wstrb 1100, wdata = data<<16.
- funct3=3'b011 → resp_err=1, no AW/W, back to IDLE after resp_ready.
- rst=1 while in ISSUE with awready=0 → next cycle awvalid=wvalid=0, req_ready=1. A following SW completes normally.
